// File: rtl/onchip_mem_arbiter.sv
// Round-robin two-master arbiter in front of a 1-cycle-latency single-port RAM.
// Read data is steered back to its owner through a two-stage tag pipeline.
module onchip_mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W/8
) (
   input  logic              clk,
   input  logic              reset_n,
   // master 0
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   // master 1
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   // RAM side
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic w_req0, w_req1, w_gnt0, w_gnt1, w_any, w_rd;
   logic r_last_grant, r_rd_v1, r_rd_own1, r_clken;
   logic r_m0_rdv, r_m1_rdv;
   logic [DATA_W-1:0] r_m0_rdata, r_m1_rdata;

   // requests are masked during reset so the RAM sees no access
   assign w_req0 = reset_n & (m0_read | m0_write);
   assign w_req1 = reset_n & (m1_read | m1_write);
   assign w_gnt0 = w_req0 & (~w_req1 | r_last_grant);
   assign w_gnt1 = w_req1 & ~w_gnt0;
   assign w_any  = w_gnt0 | w_gnt1;

   // read+write together is a write: no read data is returned for it
   assign w_rd = w_gnt1 ? (m1_read & ~m1_write) : (w_gnt0 & m0_read & ~m0_write);

   assign m0_waitrequest = w_req0 & ~w_gnt0;
   assign m1_waitrequest = w_req1 & ~w_gnt1;
   assign mem_chipselect = w_any;
   assign mem_clken      = r_clken;

   always_comb begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = 1'b0;
      if (w_gnt1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_writedata  = m1_writedata;
         mem_write      = m1_write;
      end else if (w_gnt0) begin
         mem_write      = m0_write;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_rd_v1      <= 1'b0;
         r_rd_own1    <= 1'b0;
         r_clken      <= 1'b0;
      end else begin
         r_clken   <= 1'b1;
         if (w_any) r_last_grant <= w_gnt1;
         r_rd_v1   <= w_rd;
         r_rd_own1 <= w_gnt1;
      end
   end

   // stage 2: RAM output is valid while stage 1 is valid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_m0_rdv   <= 1'b0;
         r_m1_rdv   <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         r_m0_rdv <= r_rd_v1 & ~r_rd_own1;
         r_m1_rdv <= r_rd_v1 & r_rd_own1;
         if (r_rd_v1 & ~r_rd_own1) r_m0_rdata <= mem_readdata;
         if (r_rd_v1 & r_rd_own1)  r_m1_rdata <= mem_readdata;
      end
   end

   assign m0_readdatavalid = r_m0_rdv;
   assign m1_readdatavalid = r_m1_rdv;
   assign m0_readdata      = r_m0_rdata;
   assign m1_readdata      = r_m1_rdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, scoreboard reference checked every
// cycle, a grant table, directed corner sequences and a random phase.
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;
   localparam int AW = 10, DW = 32, BW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [AW-1:0] m0_address = '0, m1_address = '0;
   logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
   logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
   logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata, mem_readdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A5A_0000 + 32'(i) * 32'h0003_0007;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RAM: registered read, byte-enabled write, everything gated by clken
   logic [DW-1:0] ram [0:1023];
   logic [DW-1:0] ram_q = '0;
   bit ram_ready;
   assign mem_readdata = ram_q;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < BW; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            ram_q <= ram[mem_address];
         end
      end
   end

   // reference: expected reads kept in a queue tagged with the cycle they are due
   typedef struct { int due; bit m; logic [31:0] d; } rd_t;
   rd_t           exp_q[$];
   logic [31:0]   ref_mem [0:1023];
   bit            ref_ready;
   int            cyc = 0;
   bit            prev_rst_hi = 1'b0;
   bit            prefer = 1'b0;
   logic [31:0]   exp_rd0 = '0, exp_rd1 = '0;
   bit            mw0 = 1'b0, mw1 = 1'b0;

   always @(negedge clk) begin
      int g;
      bit q0, q1, erv0, erv1, ewr;
      logic [AW-1:0] ea;
      logic [BW-1:0] eb;
      logic [DW-1:0] ed;
      rd_t e;
      if (!ref_ready) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
         ref_ready = 1'b1;
      end
      cyc++;
      if (!reset_n) begin
         exp_q.delete();
         prefer = 1'b0; exp_rd0 = '0; exp_rd1 = '0; mw0 = 1'b0; mw1 = 1'b0;
         chk1("rst_rdv0", m0_readdatavalid, 1'b0);
         chk1("rst_rdv1", m1_readdatavalid, 1'b0);
         chk ("rst_rd0", m0_readdata, 32'h0);
         chk ("rst_rd1", m1_readdata, 32'h0);
         chk1("rst_clken", mem_clken, 1'b0);
         chk1("rst_cs", mem_chipselect, 1'b0);
         chk1("rst_memwr", mem_write, 1'b0);
         chk1("rst_wait0", m0_waitrequest, 1'b0);
         chk1("rst_wait1", m1_waitrequest, 1'b0);
      end else begin
         chk1("clken", mem_clken, prev_rst_hi);
         q0 = m0_read | m0_write;
         q1 = m1_read | m1_write;
         if (q0 && q1) g = int'(prefer);
         else if (q0)  g = 0;
         else if (q1)  g = 1;
         else          g = -1;
         erv0 = 1'b0; erv1 = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].m) begin erv1 = 1'b1; exp_rd1 = exp_q[0].d; end
            else            begin erv0 = 1'b1; exp_rd0 = exp_q[0].d; end
            void'(exp_q.pop_front());
         end
         chk1("rdv0", m0_readdatavalid, erv0);
         chk1("rdv1", m1_readdatavalid, erv1);
         chk ("rd0", m0_readdata, exp_rd0);
         chk ("rd1", m1_readdata, exp_rd1);
         ea  = (g == 1) ? m1_address    : m0_address;
         eb  = (g == 1) ? m1_byteenable : m0_byteenable;
         ed  = (g == 1) ? m1_writedata  : m0_writedata;
         ewr = (g == 1) ? m1_write : (g == 0) ? m0_write : 1'b0;
         chk1("wait0", m0_waitrequest, q0 && g != 0);
         chk1("wait1", m1_waitrequest, q1 && g != 1);
         chk1("cs", mem_chipselect, g >= 0);
         chk1("memwr", mem_write, ewr);
         chk ("memaddr", 32'(mem_address), 32'(ea));
         if (g >= 0) begin
            chk("membe", 32'(mem_byteenable), 32'(eb));
            if (ewr) begin
               chk("memwd", mem_writedata, ed);
               for (int b = 0; b < BW; b++)
                  if (eb[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
            end else begin
               e.due = cyc + 2; e.m = (g == 1); e.d = ref_mem[ea];
               exp_q.push_back(e);
            end
            prefer = (g == 0);
         end
         mw0 = q0 && g != 0;
         mw1 = q1 && g != 1;
      end
      prev_rst_hi = reset_n;
   end

   // grant table: req = {r0,w0,r1,w1}, exp = {wait0,wait1,cs,mem_write}
   typedef struct { logic [3:0] req; logic [3:0] exp; bit sel1; } vec_t;
   vec_t tbl [10];

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic idle_all();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   initial begin
      tbl[0] = '{4'b0000, 4'b0000, 1'b0};
      tbl[1] = '{4'b1010, 4'b0110, 1'b0};
      tbl[2] = '{4'b1010, 4'b1010, 1'b1};
      tbl[3] = '{4'b0001, 4'b0011, 1'b1};
      tbl[4] = '{4'b1010, 4'b0110, 1'b0};
      tbl[5] = '{4'b1000, 4'b0010, 1'b0};
      tbl[6] = '{4'b0101, 4'b1011, 1'b1};
      tbl[7] = '{4'b1100, 4'b0011, 1'b0};
      tbl[8] = '{4'b1011, 4'b1011, 1'b1};
      tbl[9] = '{4'b0000, 4'b0000, 1'b0};

      // reset and mem_clken bring-up
      repeat (3) nxt();
      nxt(); reset_n = 1'b1;
      @(negedge clk); chk1("clken_pre", mem_clken, 1'b0);
      nxt();
      @(negedge clk); chk1("clken_post", mem_clken, 1'b1);

      m0_address = 10'h0AA; m0_byteenable = 4'hF; m0_writedata = 32'h1234_5678;
      m1_address = 10'h155; m1_byteenable = 4'h3; m1_writedata = 32'h9ABC_DEF0;
      for (int i = 0; i < 10; i++) begin
         nxt();
         {m0_read, m0_write, m1_read, m1_write} = tbl[i].req;
         @(negedge clk);
         chk1($sformatf("tbl%0d_wait0", i), m0_waitrequest, tbl[i].exp[3]);
         chk1($sformatf("tbl%0d_wait1", i), m1_waitrequest, tbl[i].exp[2]);
         chk1($sformatf("tbl%0d_cs", i), mem_chipselect, tbl[i].exp[1]);
         chk1($sformatf("tbl%0d_wr", i), mem_write, tbl[i].exp[0]);
         chk($sformatf("tbl%0d_addr", i), 32'(mem_address), tbl[i].sel1 ? 32'h155 : 32'h0AA);
      end

      // write then read, same address, back to back
      nxt(); idle_all();
      m0_write = 1'b1; m0_address = 10'h005; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
      nxt(); m0_write = 1'b0; m0_read = 1'b1;
      @(negedge clk); chk1("wr_rd_wait0", m0_waitrequest, 1'b0);
      nxt(); idle_all();
      @(negedge clk); chk1("wr_rd_early", m0_readdatavalid, 1'b0);
      nxt();
      @(negedge clk);
      chk1("wr_rd_rdv0", m0_readdatavalid, 1'b1);
      chk ("wr_rd_data", m0_readdata, 32'hDEAD_BEEF);
      chk1("wr_rd_rdv1", m1_readdatavalid, 1'b0);

      // byte lanes at the top address
      nxt(); m0_write = 1'b1; m0_address = 10'h3FF; m0_byteenable = 4'hF; m0_writedata = 32'h1122_3344;
      nxt(); m0_byteenable = 4'b0101; m0_writedata = 32'hAABB_CCDD;
      nxt(); m0_write = 1'b0; m0_read = 1'b1;
      nxt(); idle_all();
      nxt();
      @(negedge clk);
      chk1("be_rdv0", m0_readdatavalid, 1'b1);
      chk ("be_data", m0_readdata, 32'h11BB_33DD);

      // contention from reset: strict alternation, m0 first
      nxt(); idle_all(); reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_rd0", m0_readdata, 32'h0);
      chk1("rst_mid_clken", mem_clken, 1'b0);
      nxt(); reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         nxt();
         m0_read = 1'b1; m1_read = 1'b1;
         m0_address = 10'h010 + AW'((k + 1) / 2);
         m1_address = 10'h200 + AW'(k / 2);
         @(negedge clk);
         chk1("cont_wait0", m0_waitrequest, (k % 2) == 1);
         chk1("cont_wait1", m1_waitrequest, (k % 2) == 0);
      end
      nxt(); idle_all();
      repeat (3) nxt();

      // streaming: m1 alone, 16 back-to-back reads
      for (int k = 0; k < 18; k++) begin
         nxt();
         if (k < 16) begin m1_read = 1'b1; m1_address = 10'h100 + AW'(k); end
         else idle_all();
         @(negedge clk);
         if (k < 16) chk1("strm_wait1", m1_waitrequest, 1'b0);
         chk1("strm_rdv1", m1_readdatavalid, k >= 2);
         if (k >= 2) chk("strm_data", m1_readdata, init_word(256 + k - 2));
      end

      // reset pulse while a read is in flight
      nxt(); m0_read = 1'b1; m0_address = 10'h020;
      nxt(); idle_all(); reset_n = 1'b0;
      @(negedge clk);
      chk("rstrd_rd0", m0_readdata, 32'h0);
      chk("rstrd_rd1", m1_readdata, 32'h0);
      nxt(); reset_n = 1'b1;
      @(negedge clk);
      chk1("rstrd_no_rdv0", m0_readdatavalid, 1'b0);
      chk ("rstrd_rd0_after", m0_readdata, 32'h0);
      nxt();

      // random traffic; a stalled master holds its request
      for (int k = 0; k < 600; k++) begin
         nxt();
         if (!mw0) begin
            int op = $urandom_range(0, 5);
            m0_read  = (op == 2 || op == 3 || op == 5);
            m0_write = (op >= 4);
            m0_address = AW'($urandom_range(0, 23));
            m0_byteenable = BW'($urandom);
            m0_writedata = $urandom;
         end
         if (!mw1) begin
            int op = $urandom_range(0, 5);
            m1_read  = (op == 2 || op == 3 || op == 5);
            m1_write = (op >= 4);
            m1_address = AW'($urandom_range(0, 23));
            m1_byteenable = BW'($urandom);
            m1_writedata = $urandom;
         end
      end
      nxt(); idle_all();
      repeat (4) nxt();
      @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
